// File: rtl/zap_wb_pkg.sv
// zap_wb_pkg
// Shared definitions for the ZAP Wishbone interconnect:
//   - slave index constants (position of each slave in the o_s_cyc/o_s_stb,
//     i_s_ack and i_s_dat vectors)
//   - arbiter FSM state encoding
//   - default address windows
//   - in_window(): inclusive window test
package zap_wb_pkg;

    localparam int NUM_SLAVES = 4;

    localparam int SLV_RAM   = 0;
    localparam int SLV_UART  = 1;
    localparam int SLV_TIMER = 2;
    localparam int SLV_VIC   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam logic [31:0] DEF_UART_LO  = 32'hFFFF_FFE0;
    localparam logic [31:0] DEF_UART_HI  = 32'hFFFF_FFFF;
    localparam logic [31:0] DEF_TIMER_LO = 32'hFFFF_FFC0;
    localparam logic [31:0] DEF_TIMER_HI = 32'hFFFF_FFDF;
    localparam logic [31:0] DEF_VIC_LO   = 32'hFFFF_FFA0;
    localparam logic [31:0] DEF_VIC_HI   = 32'hFFFF_FFBF;

    // Inclusive window test written as an offset compare. Subtracting the
    // base first means a window ending at 32'hFFFFFFFF needs no special
    // case and no compare ever degenerates into a constant.
    function automatic logic in_window(input logic [31:0] adr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (adr - lo) <= (hi - lo);
    endfunction

endpackage

// File: rtl/zap_wb_addr_decode.sv
// zap_wb_addr_decode
// Purely combinational address decoder: maps a bus address to a one-hot
// slave select. Priority UART, TIMER, VIC; anything else falls to RAM.
// Ports:
//   i_adr  in  32  address of the granted master
//   o_sel  out 4   one-hot slave select (index = SLV_* constant)
module zap_wb_addr_decode
    import zap_wb_pkg::*;
#(
    parameter logic [31:0] UART_LO  = DEF_UART_LO,
    parameter logic [31:0] UART_HI  = DEF_UART_HI,
    parameter logic [31:0] TIMER_LO = DEF_TIMER_LO,
    parameter logic [31:0] TIMER_HI = DEF_TIMER_HI,
    parameter logic [31:0] VIC_LO   = DEF_VIC_LO,
    parameter logic [31:0] VIC_HI   = DEF_VIC_HI
) (
    input  logic [31:0]           i_adr,
    output logic [NUM_SLAVES-1:0] o_sel
);

    always_comb begin
        o_sel = '0;
        if (in_window(i_adr, UART_LO, UART_HI)) begin
            o_sel[SLV_UART] = 1'b1;
        end else if (in_window(i_adr, TIMER_LO, TIMER_HI)) begin
            o_sel[SLV_TIMER] = 1'b1;
        end else if (in_window(i_adr, VIC_LO, VIC_HI)) begin
            o_sel[SLV_VIC] = 1'b1;
        end else begin
            o_sel[SLV_RAM] = 1'b1;
        end
    end

endmodule

// File: rtl/zap_wb_interconnect.sv
// zap_wb_interconnect
// Two-master, four-slave Wishbone B3 shared-bus interconnect for the ZAP
// system bus. A round-robin arbiter grants the bus for a whole CYC-framed
// cycle (bursts included); the granted master's address is decoded per beat
// to RAM / UART / TIMER / VIC. A watchdog aborts a transfer that waits
// TIMEOUT cycles without ACK, answering the master with ERR_DATA.
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_mN_cyc/stb/we/adr/dat/sel/cti master N request (N = 0, 1)
//   o_mN_dat, o_mN_ack              master N response
//   o_s_adr/dat/we/sel/cti          shared slave request bus (0 unless BUSY)
//   o_s_cyc, o_s_stb                per-slave strobes (0 RAM,1 UART,2 TIMER,3 VIC)
//   i_s_ack, i_s_dat                per-slave ACK and packed read data
//   o_grant                         one-hot current grant
//   o_timeout, o_timeout_adr        abort pulse, sticky aborted address
module zap_wb_interconnect
    import zap_wb_pkg::*;
#(
    parameter logic [31:0] UART_LO  = DEF_UART_LO,
    parameter logic [31:0] UART_HI  = DEF_UART_HI,
    parameter logic [31:0] TIMER_LO = DEF_TIMER_LO,
    parameter logic [31:0] TIMER_HI = DEF_TIMER_HI,
    parameter logic [31:0] VIC_LO   = DEF_VIC_LO,
    parameter logic [31:0] VIC_HI   = DEF_VIC_HI,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_DEAD
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_m0_cyc,
    input  logic                     i_m0_stb,
    input  logic                     i_m0_we,
    input  logic [31:0]              i_m0_adr,
    input  logic [31:0]              i_m0_dat,
    input  logic [3:0]               i_m0_sel,
    input  logic [2:0]               i_m0_cti,
    output logic [31:0]              o_m0_dat,
    output logic                     o_m0_ack,
    input  logic                     i_m1_cyc,
    input  logic                     i_m1_stb,
    input  logic                     i_m1_we,
    input  logic [31:0]              i_m1_adr,
    input  logic [31:0]              i_m1_dat,
    input  logic [3:0]               i_m1_sel,
    input  logic [2:0]               i_m1_cti,
    output logic [31:0]              o_m1_dat,
    output logic                     o_m1_ack,
    output logic [31:0]              o_s_adr,
    output logic [31:0]              o_s_dat,
    output logic                     o_s_we,
    output logic [3:0]               o_s_sel,
    output logic [2:0]               o_s_cti,
    output logic [NUM_SLAVES-1:0]    o_s_cyc,
    output logic [NUM_SLAVES-1:0]    o_s_stb,
    input  logic [NUM_SLAVES-1:0]    i_s_ack,
    input  logic [32*NUM_SLAVES-1:0] i_s_dat,
    output logic [1:0]               o_grant,
    output logic                     o_timeout,
    output logic [31:0]              o_timeout_adr
);

    localparam int CNT_MIN_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W     = (CNT_MIN_W > 8) ? CNT_MIN_W : 8;
    // The abort decision is taken in the last wait cycle, so the counter
    // never has to hold TIMEOUT itself; an ACK in that cycle still wins.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state, w_state_next;
    logic [1:0]       r_grant, w_grant_next;
    logic             r_rr_last, w_rr_last_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [31:0]      r_timeout_adr, w_timeout_adr_next;

    // ---------------------------------------------------------------
    // Granted-master request mux (r_grant[1] selects m1)
    // ---------------------------------------------------------------
    logic        w_g_m1;
    logic        w_g_cyc, w_g_stb, w_g_we;
    logic [31:0] w_g_adr, w_g_dat;
    logic [3:0]  w_g_sel;
    logic [2:0]  w_g_cti;

    assign w_g_m1  = r_grant[1];
    assign w_g_cyc = w_g_m1 ? i_m1_cyc : i_m0_cyc;
    assign w_g_stb = w_g_m1 ? i_m1_stb : i_m0_stb;
    assign w_g_we  = w_g_m1 ? i_m1_we  : i_m0_we;
    assign w_g_adr = w_g_m1 ? i_m1_adr : i_m0_adr;
    assign w_g_dat = w_g_m1 ? i_m1_dat : i_m0_dat;
    assign w_g_sel = w_g_m1 ? i_m1_sel : i_m0_sel;
    assign w_g_cti = w_g_m1 ? i_m1_cti : i_m0_cti;

    // ---------------------------------------------------------------
    // Slave decode and response select (follows the address every beat)
    // ---------------------------------------------------------------
    logic [NUM_SLAVES-1:0]       w_slv_sel;
    logic                        w_slv_ack;
    logic [NUM_SLAVES-1:0][31:0] w_dat_masked;
    logic [31:0]                 w_slv_dat;

    zap_wb_addr_decode #(
        .UART_LO  (UART_LO),
        .UART_HI  (UART_HI),
        .TIMER_LO (TIMER_LO),
        .TIMER_HI (TIMER_HI),
        .VIC_LO   (VIC_LO),
        .VIC_HI   (VIC_HI)
    ) u_decode (
        .i_adr (w_g_adr),
        .o_sel (w_slv_sel)
    );

    assign w_slv_ack = |(i_s_ack & w_slv_sel);

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dat_mask
            assign w_dat_masked[gi] = w_slv_sel[gi] ? i_s_dat[32*gi +: 32] : 32'd0;
        end
    endgenerate

    always_comb begin
        w_slv_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_slv_dat = w_slv_dat | w_dat_masked[k];
        end
    end

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= 2'b00;
            r_rr_last     <= 1'b1;
            r_cnt         <= '0;
            r_timeout_adr <= '0;
        end else begin
            r_state       <= w_state_next;
            r_grant       <= w_grant_next;
            r_rr_last     <= w_rr_last_next;
            r_cnt         <= w_cnt_next;
            r_timeout_adr <= w_timeout_adr_next;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic: arbitration, release, watchdog
    // ---------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_grant_next       = r_grant;
        w_rr_last_next     = r_rr_last;
        w_cnt_next         = '0;
        w_timeout_adr_next = r_timeout_adr;

        case (r_state)
            ST_IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    w_grant_next = r_rr_last ? 2'b01 : 2'b10;
                    w_state_next = ST_BUSY;
                end else if (i_m0_cyc) begin
                    w_grant_next = 2'b01;
                    w_state_next = ST_BUSY;
                end else if (i_m1_cyc) begin
                    w_grant_next = 2'b10;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_g_cyc) begin
                    w_state_next   = ST_IDLE;
                    w_grant_next   = 2'b00;
                    w_rr_last_next = w_g_m1;
                end else if (w_g_stb && !w_slv_ack) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_next       = ST_ABORT;
                        w_timeout_adr_next = w_g_adr;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                if (w_g_cyc) begin
                    w_state_next = ST_BUSY;
                end else begin
                    w_state_next   = ST_IDLE;
                    w_grant_next   = 2'b00;
                    w_rr_last_next = w_g_m1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = 2'b00;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------
    always_comb begin
        o_s_adr   = '0;
        o_s_dat   = '0;
        o_s_we    = 1'b0;
        o_s_sel   = '0;
        o_s_cti   = '0;
        o_s_cyc   = '0;
        o_s_stb   = '0;
        o_m0_ack  = 1'b0;
        o_m0_dat  = '0;
        o_m1_ack  = 1'b0;
        o_m1_dat  = '0;
        o_timeout = 1'b0;

        case (r_state)
            ST_BUSY: begin
                o_s_adr = w_g_adr;
                o_s_dat = w_g_dat;
                o_s_we  = w_g_we;
                o_s_sel = w_g_sel;
                o_s_cti = w_g_cti;
                o_s_cyc = w_slv_sel & {NUM_SLAVES{w_g_cyc}};
                o_s_stb = w_slv_sel & {NUM_SLAVES{w_g_cyc & w_g_stb}};
                if (w_g_m1) begin
                    o_m1_ack = w_slv_ack & w_g_cyc & w_g_stb;
                    o_m1_dat = w_slv_dat;
                end else begin
                    o_m0_ack = w_slv_ack & w_g_cyc & w_g_stb;
                    o_m0_dat = w_slv_dat;
                end
            end
            ST_ABORT: begin
                o_timeout = 1'b1;
                if (w_g_m1) begin
                    o_m1_ack = 1'b1;
                    o_m1_dat = ERR_DATA;
                end else begin
                    o_m0_ack = 1'b1;
                    o_m0_dat = ERR_DATA;
                end
            end
            default: ;
        endcase
    end

    assign o_grant       = r_grant;
    assign o_timeout_adr = r_timeout_adr;

endmodule

// File: tb/tb_zap_wb_interconnect.sv
// Testbench for zap_wb_interconnect (TIMEOUT = 4). Inputs change 1 ns after
// each rising edge, outputs are compared 1 ns later.
module tb_zap_wb_interconnect;

    logic         clk = 1'b0;
    logic         rst;
    logic         m0_cyc, m0_stb, m0_we;
    logic [31:0]  m0_adr, m0_dat;
    logic [3:0]   m0_sel;
    logic [2:0]   m0_cti;
    logic [31:0]  m0_rdat;
    logic         m0_ack;
    logic         m1_cyc, m1_stb, m1_we;
    logic [31:0]  m1_adr, m1_dat;
    logic [3:0]   m1_sel;
    logic [2:0]   m1_cti;
    logic [31:0]  m1_rdat;
    logic         m1_ack;
    logic [31:0]  s_adr, s_dat;
    logic         s_we;
    logic [3:0]   s_sel;
    logic [2:0]   s_cti;
    logic [3:0]   s_cyc, s_stb;
    logic [3:0]   s_ack;
    logic [127:0] s_rdat;
    logic [1:0]   grant;
    logic         tmo;
    logic [31:0]  tmo_adr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    zap_wb_interconnect #(.TIMEOUT(4)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_m0_cyc      (m0_cyc),
        .i_m0_stb      (m0_stb),
        .i_m0_we       (m0_we),
        .i_m0_adr      (m0_adr),
        .i_m0_dat      (m0_dat),
        .i_m0_sel      (m0_sel),
        .i_m0_cti      (m0_cti),
        .o_m0_dat      (m0_rdat),
        .o_m0_ack      (m0_ack),
        .i_m1_cyc      (m1_cyc),
        .i_m1_stb      (m1_stb),
        .i_m1_we       (m1_we),
        .i_m1_adr      (m1_adr),
        .i_m1_dat      (m1_dat),
        .i_m1_sel      (m1_sel),
        .i_m1_cti      (m1_cti),
        .o_m1_dat      (m1_rdat),
        .o_m1_ack      (m1_ack),
        .o_s_adr       (s_adr),
        .o_s_dat       (s_dat),
        .o_s_we        (s_we),
        .o_s_sel       (s_sel),
        .o_s_cti       (s_cti),
        .o_s_cyc       (s_cyc),
        .o_s_stb       (s_stb),
        .i_s_ack       (s_ack),
        .i_s_dat       (s_rdat),
        .o_grant       (grant),
        .o_timeout     (tmo),
        .o_timeout_adr (tmo_adr)
    );

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  exp_stb;
        logic [31:0] exp_dat;
    } dec_vec_t;

    typedef struct {
        logic       m0;
        logic       m1;
        logic [1:0] exp_grant;
    } rr_vec_t;

    dec_vec_t dec_tab[10];
    rr_vec_t  rr_tab[12];

    localparam logic [31:0] RAM_D = 32'h00AA_00AA;
    localparam logic [31:0] UAR_D = 32'h1111_1111;
    localparam logic [31:0] TMR_D = 32'h2222_2222;
    localparam logic [31:0] VIC_D = 32'h3333_3333;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat = 0; m0_sel = 4'hF; m0_cti = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat = 0; m1_sel = 4'hF; m1_cti = 0;
        s_ack = 0; s_rdat = '0;
    endtask

    initial begin
        dec_tab[0] = '{32'h0000_0100, 4'b0001, RAM_D};
        dec_tab[1] = '{32'hFFFF_FFE0, 4'b0010, UAR_D};
        dec_tab[2] = '{32'hFFFF_FFC4, 4'b0100, TMR_D};
        dec_tab[3] = '{32'hFFFF_FFA8, 4'b1000, VIC_D};
        dec_tab[4] = '{32'hFFFF_FFFF, 4'b0010, UAR_D};
        dec_tab[5] = '{32'hFFFF_FFDF, 4'b0100, TMR_D};
        dec_tab[6] = '{32'hFFFF_FFC0, 4'b0100, TMR_D};
        dec_tab[7] = '{32'hFFFF_FFBF, 4'b1000, VIC_D};
        dec_tab[8] = '{32'hFFFF_FFA0, 4'b1000, VIC_D};
        dec_tab[9] = '{32'hFFFF_FF9F, 4'b0001, RAM_D};

        rr_tab[0]  = '{1'b1, 1'b1, 2'b00};
        rr_tab[1]  = '{1'b1, 1'b1, 2'b01};
        rr_tab[2]  = '{1'b1, 1'b1, 2'b01};
        rr_tab[3]  = '{1'b0, 1'b1, 2'b01};
        rr_tab[4]  = '{1'b1, 1'b1, 2'b00};
        rr_tab[5]  = '{1'b1, 1'b1, 2'b10};
        rr_tab[6]  = '{1'b1, 1'b1, 2'b10};
        rr_tab[7]  = '{1'b1, 1'b0, 2'b10};
        rr_tab[8]  = '{1'b1, 1'b1, 2'b00};
        rr_tab[9]  = '{1'b1, 1'b1, 2'b01};
        rr_tab[10] = '{1'b0, 1'b0, 2'b01};
        rr_tab[11] = '{1'b0, 1'b0, 2'b00};

        rst = 1'b1;
        idle_inputs();
        step();
        step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m0_dat", m0_rdat, 32'd0);
        chk("rst_timeout", 32'(tmo), 32'd0);
        chk("rst_timeout_adr", tmo_adr, 32'd0);
        rst = 1'b0;

        // ---- single master RAM read with two wait states ----
        step();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100;
        settle();
        chk("single_pre_grant_cyc", 32'(s_cyc), 32'd0);
        step(); settle();
        chk("single_s_cyc", 32'(s_cyc), 32'b0001);
        chk("single_grant", 32'(grant), 32'b01);
        chk("single_wait1_ack", 32'(m0_ack), 32'd0);
        step(); settle();
        chk("single_wait2_ack", 32'(m0_ack), 32'd0);
        step();
        s_ack = 4'b0001; s_rdat[31:0] = 32'h1234_5678;
        settle();
        chk("single_ack", 32'(m0_ack), 32'd1);
        chk("single_dat", m0_rdat, 32'h1234_5678);
        chk("single_m1_ack", 32'(m1_ack), 32'd0);
        $display("single read adr=00000100 ack=%0d dat=%08h", m0_ack, m0_rdat);
        step();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        settle();
        chk("single_release_cyc", 32'(s_cyc), 32'd0);
        step(); settle();
        chk("single_idle_grant", 32'(grant), 32'd0);

        // ---- decode table: m0 write burst, address moves per beat ----
        step();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_cti = 3'b010; m0_adr = dec_tab[0].adr;
        s_ack = 4'hF;
        s_rdat = {VIC_D, TMR_D, UAR_D, RAM_D};
        for (int i = 0; i < 10; i++) begin
            step();
            m0_adr = dec_tab[i].adr;
            m0_dat = 32'(i) + 32'h100;
            m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0000;
            settle();
            chk($sformatf("dec%0d_stb", i), 32'(s_stb), 32'(dec_tab[i].exp_stb));
            chk($sformatf("dec%0d_cyc", i), 32'(s_cyc), 32'(dec_tab[i].exp_stb));
            chk($sformatf("dec%0d_adr", i), s_adr, dec_tab[i].adr);
            chk($sformatf("dec%0d_wdat", i), s_dat, 32'(i) + 32'h100);
            chk($sformatf("dec%0d_m0_dat", i), m0_rdat, dec_tab[i].exp_dat);
            chk($sformatf("dec%0d_m0_ack", i), 32'(m0_ack), 32'd1);
            chk($sformatf("dec%0d_m1_ack", i), 32'(m1_ack), 32'd0);
            chk($sformatf("dec%0d_m1_dat", i), m1_rdat, 32'd0);
            chk($sformatf("dec%0d_grant", i), 32'(grant), 32'b01);
            $display("decode adr=%08h stb=%04b dat=%08h", m0_adr, s_stb, m0_rdat);
        end
        step();
        idle_inputs();
        step(); settle();
        chk("dec_idle_grant", 32'(grant), 32'd0);
        chk("dec_idle_s_adr", s_adr, 32'd0);

        // ---- tie and round robin (fresh reset so m0 wins the first tie) ----
        step(); rst = 1;
        step(); rst = 0;
        s_ack = 4'hF;
        for (int c = 0; c < 12; c++) begin
            step();
            m0_cyc = rr_tab[c].m0; m0_stb = rr_tab[c].m0;
            m1_cyc = rr_tab[c].m1; m1_stb = rr_tab[c].m1;
            settle();
            chk($sformatf("rr_c%0d_grant", c), 32'(grant), 32'(rr_tab[c].exp_grant));
            $display("rr cycle %0d m0=%0d m1=%0d grant=%02b", c, m0_cyc, m1_cyc, grant);
        end
        idle_inputs();
        step();

        // ---- timeout: m1 reads VIC, VIC never acks ----
        step();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'hFFFF_FFA4;
        settle();
        chk("tmo_pre_timeout", 32'(tmo), 32'd0);
        for (int w = 1; w <= 4; w++) begin
            step(); settle();
            chk($sformatf("tmo_wait%0d_stb", w), 32'(s_stb), 32'b1000);
            chk($sformatf("tmo_wait%0d_timeout", w), 32'(tmo), 32'd0);
            chk($sformatf("tmo_wait%0d_m1_ack", w), 32'(m1_ack), 32'd0);
        end
        step(); settle();
        chk("tmo_abort_s_cyc", 32'(s_cyc), 32'd0);
        chk("tmo_abort_s_stb", 32'(s_stb), 32'd0);
        chk("tmo_abort_m1_ack", 32'(m1_ack), 32'd1);
        chk("tmo_abort_m1_dat", m1_rdat, 32'hDEAD_DEAD);
        chk("tmo_abort_m0_ack", 32'(m0_ack), 32'd0);
        chk("tmo_abort_pulse", 32'(tmo), 32'd1);
        chk("tmo_abort_adr", tmo_adr, 32'hFFFF_FFA4);
        chk("tmo_abort_grant", 32'(grant), 32'b10);
        $display("timeout adr=%08h m1_ack=%0d dat=%08h", tmo_adr, m1_ack, m1_rdat);
        step();
        m1_cyc = 0; m1_stb = 0;
        settle();
        chk("tmo_pulse_end", 32'(tmo), 32'd0);
        chk("tmo_adr_sticky", tmo_adr, 32'hFFFF_FFA4);
        step();

        // ---- ACK arrives in the last wait cycle: ACK wins ----
        step();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'hFFFF_FFC8;
        s_rdat = {VIC_D, TMR_D, UAR_D, RAM_D};
        for (int w = 1; w <= 3; w++) begin
            step(); settle();
            chk($sformatf("race_wait%0d_ack", w), 32'(m0_ack), 32'd0);
        end
        step();
        s_ack = 4'b0100;
        settle();
        chk("race_ack", 32'(m0_ack), 32'd1);
        chk("race_dat", m0_rdat, TMR_D);
        chk("race_timeout", 32'(tmo), 32'd0);
        $display("race adr=%08h ack=%0d timeout=%0d", m0_adr, m0_ack, tmo);
        step();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        settle();
        chk("race_no_abort_timeout", 32'(tmo), 32'd0);
        chk("race_no_abort_ack", 32'(m0_ack), 32'd0);
        step();

        // ---- reset in the middle of a RAM burst ----
        step();
        m0_cyc = 1; m0_stb = 1; m0_cti = 3'b010; m0_adr = 32'h0000_0200;
        s_ack = 4'b0001;
        step(); settle();
        chk("burst_beat1_ack", 32'(m0_ack), 32'd1);
        chk("burst_beat1_adr", s_adr, 32'h0000_0200);
        step();
        m0_adr = 32'h0000_0204;
        settle();
        chk("burst_beat2_ack", 32'(m0_ack), 32'd1);
        step();
        m0_adr = 32'h0000_0208; rst = 1;
        step();
        rst = 0;
        settle();
        chk("burst_rst_grant", 32'(grant), 32'd0);
        chk("burst_rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("burst_rst_s_stb", 32'(s_stb), 32'd0);
        chk("burst_rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("burst_rst_m0_dat", m0_rdat, 32'd0);
        chk("burst_rst_s_adr", s_adr, 32'd0);
        chk("burst_rst_timeout_adr", tmo_adr, 32'd0);
        $display("reset mid-burst grant=%02b s_cyc=%04b", grant, s_cyc);
        step(); settle();
        chk("burst_regrant", 32'(grant), 32'b01);
        chk("burst_regrant_s_cyc", 32'(s_cyc), 32'b0001);
        chk("burst_regrant_ack", 32'(m0_ack), 32'd1);
        step();
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
